// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter.
// Block geometry is fixed at 16 bytes, so the block offset is the low 4 address bits.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FILL,
        DONE
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int BLOCK_BYTES = 16;
    localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);

endpackage

// File: rtl/mem_arbiter_fill_seq.sv
// Block-fill sequencer: latches the aligned block base, counts issued reads and
// returned words, and generates the issue and fill byte addresses.
module fill_seq
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              active,
    input  logic              rx_valid,
    output logic              issue_done,
    output logic [ADDR_W-1:0] issue_addr,
    output logic              rx_we,
    output logic [ADDR_W-1:0] rx_addr,
    output logic              rx_done
);

    localparam int RC_W = $clog2(BLOCK_WORDS);
    localparam int IC_W = RC_W + 1;
    localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFFSET_BITS) - ADDR_W'(1));

    logic [ADDR_W-1:0] base;
    logic [IC_W-1:0]   ic;
    logic [RC_W-1:0]   rc;

    // A new grant clears both counters; they only advance while the fill is active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base <= '0;
            ic   <= '0;
            rc   <= '0;
        end else if (start) begin
            base <= start_addr & BASE_MASK;
            ic   <= '0;
            rc   <= '0;
        end else if (active) begin
            if (!issue_done) begin
                ic <= ic + IC_W'(1);
            end
            if (rx_valid) begin
                rc <= rc + RC_W'(1);
            end
        end
    end

    always_comb begin
        issue_done = (ic == IC_W'(BLOCK_WORDS));
        issue_addr = base + (ADDR_W'(ic) << 1);
        rx_we      = active && rx_valid;
        rx_addr    = base + (ADDR_W'(rc) << 1);
        rx_done    = rx_we && (rc == RC_W'(BLOCK_WORDS - 1));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between I-cache fills, D-cache fills
// and D-side write-through stores; stores win, tied misses alternate.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int MEM_LAT     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    output logic              i_fill_we,
    output logic [ADDR_W-1:0] i_fill_addr,
    output logic              i_fill_done,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              d_fill_we,
    output logic [ADDR_W-1:0] d_fill_addr,
    output logic              d_fill_done,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_wr_ack,
    output logic [DATA_W-1:0] fill_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid
);

    localparam int DROP_W = $clog2(MEM_LAT + 1);

    arb_state_t        state, state_next;
    owner_t            owner, grant_owner, last_grant;
    logic              grant;
    logic [ADDR_W-1:0] grant_addr;
    logic [DROP_W-1:0] drop_cnt;
    logic              rx_valid;
    logic              issue_done, rx_we, rx_done;
    logic [ADDR_W-1:0] issue_addr, rx_addr;

    assign fill_data = mem_rdata;

    // Reads issued before a reset can still return for MEM_LAT cycles afterwards;
    // no legitimate return can arrive that early, so those cycles are masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= DROP_W'(MEM_LAT);
        end else if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - DROP_W'(1);
        end
    end

    assign rx_valid   = mem_data_valid && (drop_cnt == '0);
    assign grant_addr = (grant_owner == OWN_D) ? d_miss_addr : i_miss_addr;

    fill_seq #(
        .ADDR_W      (ADDR_W),
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_fill_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (grant),
        .start_addr (grant_addr),
        .active     (state == FILL),
        .rx_valid   (rx_valid),
        .issue_done (issue_done),
        .issue_addr (issue_addr),
        .rx_we      (rx_we),
        .rx_addr    (rx_addr),
        .rx_done    (rx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
        end else begin
            state <= state_next;
            if (grant) begin
                owner <= grant_owner;
            end
            if (state == DONE) begin
                last_grant <= owner;
            end
        end
    end

    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_owner = owner;
        i_fill_we   = 1'b0;
        i_fill_addr = '0;
        i_fill_done = 1'b0;
        d_fill_we   = 1'b0;
        d_fill_addr = '0;
        d_fill_done = 1'b0;
        d_wr_ack    = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        unique case (state)
            IDLE: begin
                if (d_wr_req) begin
                    state_next = WRITE;
                end else if (i_miss || d_miss) begin
                    grant      = 1'b1;
                    state_next = FILL;
                    if (i_miss && d_miss) begin
                        grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
                    end else begin
                        grant_owner = d_miss ? OWN_D : OWN_I;
                    end
                end
            end
            WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_wr_addr;
                mem_wdata  = d_wr_data;
                d_wr_ack   = 1'b1;
                state_next = IDLE;
            end
            FILL: begin
                mem_en   = !issue_done;
                mem_addr = issue_done ? '0 : issue_addr;
                if (rx_we) begin
                    if (owner == OWN_D) begin
                        d_fill_we   = 1'b1;
                        d_fill_addr = rx_addr;
                    end else begin
                        i_fill_we   = 1'b1;
                        i_fill_addr = rx_addr;
                    end
                end
                if (rx_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                d_fill_done = (owner == OWN_D);
                i_fill_done = (owner == OWN_I);
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 4-cycle pipelined memory model whose
// read data is the address XOR 16'h5A5A.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        i_fill_we, i_fill_done, d_fill_we, d_fill_done, d_wr_ack;
    logic [15:0] i_fill_addr, d_fill_addr, fill_data;
    logic        mem_en, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        inj_valid;

    logic [3:0]  pv = '0;
    logic [15:0] pd [4];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .i_fill_we      (i_fill_we),
        .i_fill_addr    (i_fill_addr),
        .i_fill_done    (i_fill_done),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .d_fill_we      (d_fill_we),
        .d_fill_addr    (d_fill_addr),
        .d_fill_done    (d_fill_done),
        .d_wr_req       (d_wr_req),
        .d_wr_addr      (d_wr_addr),
        .d_wr_data      (d_wr_data),
        .d_wr_ack       (d_wr_ack),
        .fill_data      (fill_data),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid)
    );

    // Memory model ignores rst_n so reads in flight at reset still come back.
    always @(posedge clk) begin
        pv[0] <= mem_en && !mem_wr;
        pd[0] <= mem_addr ^ 16'h5A5A;
        for (int i = 1; i < 4; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mem_data_valid = pv[3] | inj_valid;
    assign mem_rdata      = pv[3] ? pd[3] : 16'h0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [70:0] obs();
        return {mem_en, mem_wr, mem_addr, mem_wdata,
                i_fill_we, i_fill_addr, i_fill_done,
                d_fill_we, d_fill_addr, d_fill_done, d_wr_ack};
    endfunction

    // Expected outputs in cycle c (1 = first cycle after the grant edge) of a fill.
    function automatic logic [70:0] fill_vec(int c, bit d_side, logic [15:0] base);
        logic        en, we, done;
        logic [15:0] ma, fa;
        en   = (c >= 1) && (c <= 8);
        ma   = en ? base + 16'(2 * (c - 1)) : 16'h0000;
        we   = (c >= 5) && (c <= 12);
        fa   = we ? base + 16'(2 * (c - 5)) : 16'h0000;
        done = (c == 13);
        return {en, 1'b0, ma, 16'h0000,
                d_side ? 18'h0 : {we, fa, done},
                d_side ? {we, fa, done} : 18'h0,
                1'b0};
    endfunction

    function automatic logic [70:0] write_vec(logic [15:0] a, logic [15:0] d);
        return {1'b1, 1'b1, a, d, 18'h0, 18'h0, 1'b1};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs() !== 71'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", obs());
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (obs() !== 71'h0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: got %h expected 0", obs());
        end
    endtask

    task automatic test_i_fill();
        logic [70:0] e;
        logic [15:0] ed;
        i_miss      = 1'b1;
        i_miss_addr = 16'h1237;
        for (int c = 1; c <= 14; c++) begin
            tick();
            e = fill_vec(c, 1'b0, 16'h1230);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL i_fill cycle %0d: got %h expected %h", c, obs(), e);
            end
            if (c >= 5 && c <= 12) begin
                ed = (16'h1230 + 16'(2 * (c - 5))) ^ 16'h5A5A;
                n_cmp++;
                if (fill_data !== ed) begin
                    n_fail++;
                    $display("[TB] FAIL i_fill_data cycle %0d: got %h expected %h", c, fill_data, ed);
                end
            end
            if (c == 13) i_miss = 1'b0;
        end
    endtask

    task automatic test_tie();
        logic [70:0] e;
        logic [15:0] base;
        bit          d_side;
        rst_n = 1'b0;
        tick();
        rst_n       = 1'b1;
        i_miss      = 1'b1;
        i_miss_addr = 16'h2005;
        d_miss      = 1'b1;
        d_miss_addr = 16'h3008;
        for (int r = 0; r < 3; r++) begin
            d_side = (r % 2 == 0);
            base   = d_side ? 16'h3000 : 16'h2000;
            for (int c = 1; c <= 14; c++) begin
                tick();
                e = fill_vec(c, d_side, base);
                n_cmp++;
                if (obs() !== e) begin
                    n_fail++;
                    $display("[TB] FAIL tie round %0d cycle %0d: got %h expected %h", r, c, obs(), e);
                end
                if (c == 13) begin
                    if (d_side) d_miss = 1'b0;
                    else        i_miss = 1'b0;
                end
                if (c == 14) begin
                    if (r < 2) begin
                        if (d_side) d_miss = 1'b1;
                        else        i_miss = 1'b1;
                    end else begin
                        i_miss = 1'b0;
                    end
                end
            end
        end
        tick();
        n_cmp++;
        if (obs() !== 71'h0) begin
            n_fail++;
            $display("[TB] FAIL tie_idle: got %h expected 0", obs());
        end
    endtask

    task automatic test_store_then_fill();
        logic [70:0] e;
        d_wr_req    = 1'b1;
        d_wr_addr   = 16'h4000;
        d_wr_data   = 16'hBEEF;
        d_miss      = 1'b1;
        d_miss_addr = 16'h5006;
        tick();
        e = write_vec(16'h4000, 16'hBEEF);
        n_cmp++;
        if (obs() !== e) begin
            n_fail++;
            $display("[TB] FAIL store_first: got %h expected %h", obs(), e);
        end
        d_wr_req = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== 71'h0) begin
            n_fail++;
            $display("[TB] FAIL store_idle_gap: got %h expected 0", obs());
        end
        for (int c = 1; c <= 14; c++) begin
            tick();
            e = fill_vec(c, 1'b1, 16'h5000);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL store_then_fill cycle %0d: got %h expected %h", c, obs(), e);
            end
            if (c == 13) d_miss = 1'b0;
        end
    endtask

    task automatic test_store_mid_fill();
        logic [70:0] e;
        logic [15:0] ed;
        i_miss      = 1'b1;
        i_miss_addr = 16'h6000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c <= 14)      e = fill_vec(c, 1'b0, 16'h6000);
            else if (c == 15) e = write_vec(16'h7002, 16'h1234);
            else              e = 71'h0;
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL store_mid_fill cycle %0d: got %h expected %h", c, obs(), e);
            end
            if (c >= 5 && c <= 12) begin
                ed = (16'h6000 + 16'(2 * (c - 5))) ^ 16'h5A5A;
                n_cmp++;
                if (fill_data !== ed) begin
                    n_fail++;
                    $display("[TB] FAIL mid_fill_data cycle %0d: got %h expected %h", c, fill_data, ed);
                end
            end
            if (c == 3) begin
                d_wr_req  = 1'b1;
                d_wr_addr = 16'h7002;
                d_wr_data = 16'h1234;
            end
            if (c == 13) i_miss   = 1'b0;
            if (c == 15) d_wr_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [70:0] e;
        d_miss      = 1'b1;
        d_miss_addr = 16'h8010;
        for (int c = 1; c <= 6; c++) begin
            tick();
            e = fill_vec(c, 1'b1, 16'h8010);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL pre_reset cycle %0d: got %h expected %h", c, obs(), e);
            end
        end
        rst_n  = 1'b0;
        d_miss = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 71'h0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h expected 0", obs());
        end
        tick();
        rst_n = 1'b1;
        for (int c = 8; c <= 11; c++) begin
            tick();
            n_cmp++;
            if (obs() !== 71'h0) begin
                n_fail++;
                $display("[TB] FAIL stale_return cycle %0d: got %h expected 0", c, obs());
            end
        end
        i_miss      = 1'b1;
        i_miss_addr = 16'h9004;
        for (int c = 1; c <= 14; c++) begin
            tick();
            e = fill_vec(c, 1'b0, 16'h9000);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL post_reset_fill cycle %0d: got %h expected %h", c, obs(), e);
            end
            if (c == 13) i_miss = 1'b0;
        end
    endtask

    task automatic test_idle_valid();
        logic [70:0] e;
        inj_valid = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            tick();
            n_cmp++;
            if (obs() !== 71'h0) begin
                n_fail++;
                $display("[TB] FAIL idle_valid cycle %0d: got %h expected 0", c, obs());
            end
        end
        inj_valid   = 1'b0;
        d_miss      = 1'b1;
        d_miss_addr = 16'hA00C;
        for (int c = 1; c <= 14; c++) begin
            tick();
            e = fill_vec(c, 1'b1, 16'hA000);
            n_cmp++;
            if (obs() !== e) begin
                n_fail++;
                $display("[TB] FAIL fill_after_idle_valid cycle %0d: got %h expected %h", c, obs(), e);
            end
            if (c == 13) d_miss = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        i_miss      = 1'b0;
        d_miss      = 1'b0;
        d_wr_req    = 1'b0;
        i_miss_addr = '0;
        d_miss_addr = '0;
        d_wr_addr   = '0;
        d_wr_data   = '0;
        inj_valid   = 1'b0;
        test_reset();
        test_i_fill();
        test_tie();
        test_store_then_fill();
        test_store_mid_fill();
        test_reset_mid_fill();
        test_idle_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
